// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Quotient reported for a zero divisor; sliced to the operand width by users
    localparam logic [63:0] DIV0_QUOTIENT = '1;

    // Iteration counter width: $clog2(w), never narrower than one bit
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring division step
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   r,
    input  logic         in_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   next_r,
    output logic         q_bit
);

    logic [W:0] r_shift;
    logic [W:0] diff;
    logic       no_borrow;

    // Shift the next dividend bit in; the bit shifted out of r is always zero
    // because the restored remainder is below the divisor
    assign r_shift = (r << 1) | {{W{1'b0}}, in_bit};

    rc_adder #(.N(W + 1)) u_sub (
        .a    (r_shift),
        .b    ({1'b0, divisor}),
        .sub  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    // Keep the difference only when it did not go negative
    always_comb begin
        q_bit  = no_borrow;
        next_r = no_borrow ? diff : r_shift;
    end

endmodule

// File: rtl/rc_adder.sv
// rtl/rc_adder.sv - ripple-carry adder/subtractor, carry-out is the not-borrow flag when sub=1
module rc_adder #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0]   c;
    logic [N-1:0] bx;

    // Bitwise ripple chain; subtraction is a + ~b + 1
    always_comb begin
        c    = '0;
        bx   = b ^ {N{sub}};
        c[0] = sub;
        for (int i = 0; i < N; i++) begin
            sum[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1]   = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
        end
        cout = c[N];
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring unsigned divider with valid/ready handshakes
module seq_divider
    import div_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(W);

    div_state_e    state, state_n;
    logic [W:0]    r_q;
    logic [W-1:0]  sreg_q;
    logic [W-1:0]  dsr_q;
    logic [CW-1:0] cnt_q;
    logic          dz_q;
    logic [W:0]    step_r;
    logic          step_q;

    div_step #(.W(W)) u_step (
        .r       (r_q),
        .in_bit  (sreg_q[W-1]),
        .divisor (dsr_q),
        .next_r  (step_r),
        .q_bit   (step_q)
    );

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = sreg_q;
    assign remainder   = r_q[W-1:0];
    assign div_by_zero = dz_q;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // Next state: zero divisor short-circuits straight to DONE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = (divisor == '0) ? DONE : BUSY;
            BUSY:    if (cnt_q == '0) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one quotient bit per BUSY cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_q    <= '0;
            sreg_q <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            dz_q   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            dsr_q <= divisor;
            cnt_q <= CW'(W - 1);
            if (divisor == '0) begin
                sreg_q <= DIV0_QUOTIENT[W-1:0];
                r_q    <= {1'b0, dividend};
                dz_q   <= 1'b1;
            end else begin
                sreg_q <= dividend;
                r_q    <= '0;
                dz_q   <= 1'b0;
            end
        end else if (state == BUSY) begin
            r_q    <= step_r;
            sreg_q <= {sreg_q[W-2:0], step_q};
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule
